// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter between icache and dcache line requests onto one memory port.
// One transaction in flight; all outputs registered; protocol/timeout faults latch err_o.
module mem_req_arbiter #(
    parameter int ADDR_WIDTH       = 32,
    parameter int CACHE_LINE_BYTES = 16,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_rd_req_i,
    input  logic [ADDR_WIDTH-1:0]         ic_addr_i,
    output logic                          ic_data_valid_o,
    output logic [CACHE_LINE_BYTES*8-1:0] ic_data_o,
    input  logic                          dc_rd_req_i,
    input  logic                          dc_wr_req_i,
    input  logic [ADDR_WIDTH-1:0]         dc_addr_i,
    input  logic [CACHE_LINE_BYTES*8-1:0] dc_wr_data_i,
    input  logic [1:0]                    dc_size_i,
    output logic                          dc_data_valid_o,
    output logic [CACHE_LINE_BYTES*8-1:0] dc_data_o,
    output logic                          dc_write_done_o,
    output logic                          rd_req_valid_o,
    output logic                          wr_req_valid_o,
    output logic                          req_is_instr_o,
    output logic [ADDR_WIDTH-1:0]         req_address_o,
    output logic [CACHE_LINE_BYTES*8-1:0] wr_data_o,
    output logic [1:0]                    req_access_size_o,
    input  logic                          mem_data_valid_i,
    input  logic                          mem_data_is_instr_i,
    input  logic [CACHE_LINE_BYTES*8-1:0] mem_data_i,
    input  logic                          mem_write_done_i,
    output logic                          err_o
);
    localparam int LW = CACHE_LINE_BYTES * 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] SIZE_LINE = 2'b11;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD_I, RD_D, WR_D, RESP} state_t;

    state_t state, state_nxt;
    logic last_grant_ic, last_grant_ic_d;
    logic [CW-1:0] tmo_cnt, tmo_cnt_d;

    logic grant_dc, grant_ic, busy, rd_state, rd_done, wr_done, timeout, err_evt;
    logic ic_valid_d, dc_valid_d, wdone_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LW-1:0] wr_data_d, ic_data_d, dc_data_d;
    logic [1:0] size_d;

    // Contended grant goes to whichever side was not served last.
    assign grant_dc = (dc_rd_req_i | dc_wr_req_i) & (~ic_rd_req_i | last_grant_ic);
    assign grant_ic = ic_rd_req_i & ~grant_dc;

    assign rd_state = (state == RD_I) || (state == RD_D);
    assign busy     = rd_state || (state == WR_D);
    assign rd_done  = rd_state && mem_data_valid_i && (mem_data_is_instr_i == (state == RD_I));
    assign wr_done  = (state == WR_D) && mem_write_done_i;
    assign timeout  = busy && !rd_done && !wr_done && (tmo_cnt == TMO_LAST);

    always_comb begin
        err_evt = timeout;
        if ((state == IDLE || state == RESP) && (mem_data_valid_i || mem_write_done_i))
            err_evt = 1'b1;
        if (rd_state && ((mem_data_valid_i && !rd_done) || mem_write_done_i))
            err_evt = 1'b1;
        if ((state == WR_D) && mem_data_valid_i)
            err_evt = 1'b1;
        if ((state == IDLE) && grant_dc && dc_rd_req_i && dc_wr_req_i)
            err_evt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            last_grant_ic     <= 1'b1;
            tmo_cnt           <= '0;
            rd_req_valid_o    <= 1'b0;
            wr_req_valid_o    <= 1'b0;
            req_is_instr_o    <= 1'b0;
            req_address_o     <= '0;
            wr_data_o         <= '0;
            req_access_size_o <= '0;
            ic_data_valid_o   <= 1'b0;
            dc_data_valid_o   <= 1'b0;
            dc_write_done_o   <= 1'b0;
            ic_data_o         <= '0;
            dc_data_o         <= '0;
            err_o             <= 1'b0;
        end else begin
            state             <= state_nxt;
            last_grant_ic     <= last_grant_ic_d;
            tmo_cnt           <= tmo_cnt_d;
            rd_req_valid_o    <= (state_nxt == RD_I) || (state_nxt == RD_D);
            wr_req_valid_o    <= (state_nxt == WR_D);
            req_is_instr_o    <= (state_nxt == RD_I);
            req_address_o     <= addr_d;
            wr_data_o         <= wr_data_d;
            req_access_size_o <= size_d;
            ic_data_valid_o   <= ic_valid_d;
            dc_data_valid_o   <= dc_valid_d;
            dc_write_done_o   <= wdone_d;
            ic_data_o         <= ic_data_d;
            dc_data_o         <= dc_data_d;
            err_o             <= err_o | err_evt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_dc)      state_nxt = dc_wr_req_i ? WR_D : RD_D;
                else if (grant_ic) state_nxt = RD_I;
            end
            RD_I, RD_D: begin
                if (rd_done)      state_nxt = RESP;
                else if (timeout) state_nxt = IDLE;
            end
            WR_D: begin
                if (wr_done)      state_nxt = RESP;
                else if (timeout) state_nxt = IDLE;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        last_grant_ic_d = last_grant_ic;
        addr_d          = req_address_o;
        wr_data_d       = wr_data_o;
        size_d          = req_access_size_o;
        if (state == IDLE && grant_dc) begin
            last_grant_ic_d = 1'b0;
            addr_d          = dc_addr_i;
            size_d          = dc_size_i;
            if (dc_wr_req_i) wr_data_d = dc_wr_data_i;
        end else if (state == IDLE && grant_ic) begin
            last_grant_ic_d = 1'b1;
            addr_d          = ic_addr_i;
            size_d          = SIZE_LINE;
        end
        // Counter restarts on every state change, so each busy visit gets a full budget.
        tmo_cnt_d  = (busy && state_nxt == state) ? tmo_cnt + 1'b1 : '0;
        ic_valid_d = rd_done && (state == RD_I);
        dc_valid_d = rd_done && (state == RD_D);
        wdone_d    = wr_done;
        ic_data_d  = ic_valid_d ? mem_data_i : ic_data_o;
        dc_data_d  = dc_valid_d ? mem_data_i : dc_data_o;
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter with a transaction-level reference model
// (round-robin winner, delivered lines, sticky error) plus directed corner cases.
module tb_mem_req_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ic_rd_req_i = 0, dc_rd_req_i = 0, dc_wr_req_i = 0;
    logic [AW-1:0] ic_addr_i = '0, dc_addr_i = '0;
    logic [LW-1:0] dc_wr_data_i = '0, mem_data_i = '0;
    logic [1:0] dc_size_i = '0;
    logic mem_data_valid_i = 0, mem_data_is_instr_i = 0, mem_write_done_i = 0;
    logic ic_data_valid_o, dc_data_valid_o, dc_write_done_o;
    logic [LW-1:0] ic_data_o, dc_data_o, wr_data_o;
    logic rd_req_valid_o, wr_req_valid_o, req_is_instr_o, err_o;
    logic [AW-1:0] req_address_o;
    logic [1:0] req_access_size_o;

    mem_req_arbiter #(.ADDR_WIDTH(AW), .CACHE_LINE_BYTES(16), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ic_rd_req_i(ic_rd_req_i), .ic_addr_i(ic_addr_i),
        .ic_data_valid_o(ic_data_valid_o), .ic_data_o(ic_data_o),
        .dc_rd_req_i(dc_rd_req_i), .dc_wr_req_i(dc_wr_req_i), .dc_addr_i(dc_addr_i),
        .dc_wr_data_i(dc_wr_data_i), .dc_size_i(dc_size_i),
        .dc_data_valid_o(dc_data_valid_o), .dc_data_o(dc_data_o), .dc_write_done_o(dc_write_done_o),
        .rd_req_valid_o(rd_req_valid_o), .wr_req_valid_o(wr_req_valid_o),
        .req_is_instr_o(req_is_instr_o), .req_address_o(req_address_o),
        .wr_data_o(wr_data_o), .req_access_size_o(req_access_size_o),
        .mem_data_valid_i(mem_data_valid_i), .mem_data_is_instr_i(mem_data_is_instr_i),
        .mem_data_i(mem_data_i), .mem_write_done_i(mem_write_done_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: who was served last, last line per requester, sticky error.
    bit m_last_ic = 1;
    logic [LW-1:0] m_ic_line = '0, m_dc_line = '0;
    bit m_err = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_last_ic = 1;
        m_ic_line = '0;
        m_dc_line = '0;
        m_err     = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd"}, rd_req_valid_o, 0);
        check({tag, "_wr"}, wr_req_valid_o, 0);
        check({tag, "_instr"}, req_is_instr_o, 0);
        check({tag, "_icv"}, ic_data_valid_o, 0);
        check({tag, "_dcv"}, dc_data_valid_o, 0);
        check({tag, "_wdone"}, dc_write_done_o, 0);
        check({tag, "_icdata"}, ic_data_o, m_ic_line);
        check({tag, "_dcdata"}, dc_data_o, m_dc_line);
        check({tag, "_err"}, err_o, m_err);
    endtask

    // Serves one arbitration round: grant, hold for lat cycles, respond, check pulse and return.
    task automatic serve(input int lat);
        bit win_ic, is_wr, dc_c;
        logic [LW-1:0] line;
        dc_c = dc_rd_req_i | dc_wr_req_i;
        if (dc_c && ic_rd_req_i) win_ic = !m_last_ic;
        else win_ic = ic_rd_req_i;
        is_wr = !win_ic && dc_wr_req_i;
        m_last_ic = win_ic;
        tick();
        check("grant_rd", rd_req_valid_o, !is_wr);
        check("grant_wr", wr_req_valid_o, is_wr);
        check("grant_instr", req_is_instr_o, win_ic);
        check("grant_addr", req_address_o, win_ic ? ic_addr_i : dc_addr_i);
        check("grant_size", req_access_size_o, win_ic ? 2'd3 : dc_size_i);
        if (is_wr) check("grant_wdata", wr_data_o, dc_wr_data_i);
        for (int i = 1; i < lat; i++) begin
            tick();
            check("req_held", is_wr ? wr_req_valid_o : rd_req_valid_o, 1);
            check("no_early_pulse", ic_data_valid_o | dc_data_valid_o | dc_write_done_o, 0);
        end
        line = rnd_line();
        if (is_wr) mem_write_done_i = 1;
        else begin
            mem_data_valid_i    = 1;
            mem_data_is_instr_i = win_ic;
            mem_data_i          = line;
        end
        tick();
        mem_write_done_i = 0;
        mem_data_valid_i = 0;
        mem_data_i       = rnd_line();
        if (!is_wr) begin
            if (win_ic) m_ic_line = line;
            else m_dc_line = line;
        end
        check("resp_icv", ic_data_valid_o, win_ic);
        check("resp_dcv", dc_data_valid_o, !win_ic && !is_wr);
        check("resp_wdone", dc_write_done_o, is_wr);
        check("resp_req_low", rd_req_valid_o | wr_req_valid_o, 0);
        check("resp_icdata", ic_data_o, m_ic_line);
        check("resp_dcdata", dc_data_o, m_dc_line);
        if (win_ic) ic_rd_req_i = 0;
        else begin
            dc_rd_req_i = 0;
            dc_wr_req_i = 0;
        end
        tick();
        check("post_pulse", ic_data_valid_o | dc_data_valid_o | dc_write_done_o, 0);
        check("post_icdata", ic_data_o, m_ic_line);
        check("post_dcdata", dc_data_o, m_dc_line);
        check("post_err", err_o, m_err);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] l;
        // Reset state
        rst = 0;
        repeat (3) tick();
        rst = 1;
        check_idle_outputs("reset");

        // Both reads from reset: dc first, then ic; repeated pair keeps alternating
        for (int r = 0; r < 2; r++) begin
            ic_rd_req_i = 1; dc_rd_req_i = 1;
            ic_addr_i = 32'h1000 + r; dc_addr_i = 32'h2000 + r; dc_size_i = 2'd2;
            serve(2);
            serve(2);
        end

        // Lone icache read at 0x40, response 3 cycles after the request goes out
        ic_addr_i = 32'h40; ic_rd_req_i = 1;
        serve(3);

        // dcache write 0x100
        dc_addr_i = 32'h100; dc_wr_data_i = 128'hDEADBEEF; dc_size_i = 2'd2; dc_wr_req_i = 1;
        serve(4);

        // Randomized mix
        for (int it = 0; it < 40; it++) begin
            ic_addr_i = $urandom; dc_addr_i = $urandom;
            dc_wr_data_i = rnd_line(); dc_size_i = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: ic_rd_req_i = 1;
                1: dc_rd_req_i = 1;
                2: dc_wr_req_i = 1;
                3: begin ic_rd_req_i = 1; dc_rd_req_i = 1; end
                default: begin ic_rd_req_i = 1; dc_wr_req_i = 1; end
            endcase
            serve($urandom_range(1, 5));
            if (ic_rd_req_i | dc_rd_req_i | dc_wr_req_i) serve($urandom_range(1, 5));
        end

        // Wrong tag during dcache read: dropped and flagged, correct tag still delivered
        dc_addr_i = 32'h300; dc_rd_req_i = 1; m_last_ic = 0;
        tick();
        check("tag_grant", rd_req_valid_o, 1);
        mem_data_valid_i = 1; mem_data_is_instr_i = 1; mem_data_i = rnd_line();
        tick();
        mem_data_valid_i = 0; m_err = 1;
        check("tag_err", err_o, 1);
        check("tag_drop", dc_data_valid_o | ic_data_valid_o, 0);
        check("tag_held", rd_req_valid_o, 1);
        l = rnd_line();
        mem_data_valid_i = 1; mem_data_is_instr_i = 0; mem_data_i = l;
        tick();
        mem_data_valid_i = 0; m_dc_line = l;
        check("tag_late_vld", dc_data_valid_o, 1);
        check("tag_late_data", dc_data_o, l);
        dc_rd_req_i = 0;
        tick();

        // Timeout: request stays out for exactly TMO cycles, then abort without a pulse
        rst = 0; tick(); rst = 1; model_reset();
        check_idle_outputs("rst2");
        ic_addr_i = 32'h80; ic_rd_req_i = 1; m_last_ic = 1;
        tick();
        check("tmo_grant", rd_req_valid_o, 1);
        for (int i = 2; i <= TMO; i++) begin
            tick();
            check("tmo_busy", rd_req_valid_o, 1);
            check("tmo_no_err", err_o, 0);
        end
        ic_rd_req_i = 0;
        tick();
        m_err = 1;
        check("tmo_err", err_o, 1);
        check("tmo_idle", rd_req_valid_o, 0);
        check("tmo_no_pulse", ic_data_valid_o, 0);
        dc_addr_i = 32'h500; dc_rd_req_i = 1; dc_size_i = 2'd1;
        serve(2);
        ic_addr_i = 32'h84; ic_rd_req_i = 1; dc_rd_req_i = 1;
        serve(1);
        serve(1);

        // Reset in the middle of a dcache read, then a stray response
        dc_addr_i = 32'h600; dc_rd_req_i = 1;
        tick();
        check("mid_grant", rd_req_valid_o, 1);
        tick();
        rst = 0; dc_rd_req_i = 0;
        tick();
        rst = 1; model_reset();
        check_idle_outputs("mid_rst");
        check("mid_addr", req_address_o, 0);
        check("mid_size", req_access_size_o, 0);
        mem_data_valid_i = 1; mem_data_is_instr_i = 0; mem_data_i = rnd_line();
        tick();
        mem_data_valid_i = 0; m_err = 1;
        check_idle_outputs("stray");
        ic_addr_i = 32'h700; ic_rd_req_i = 1;
        serve(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
